// File: rtl/match_tally_pkg.sv
// Shared defaults and state encoding for the match detector and its status blocks.
package match_tally_pkg;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_RUN_W  = 8;
    localparam int DEF_THRESH = 4;

    // State mirrors the previous ans sample, so the encoding is the sample value.
    typedef enum logic {
        T_IDLE   = 1'b0,
        T_ACTIVE = 1'b1
    } tally_state_e;

endpackage

// File: rtl/match_tally_sat_inc.sv
// Saturating incrementer: adds one when enabled unless the value is already all-ones.
module sat_inc
    import match_tally_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] val,
    input  logic         en,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = val;
        if (en && (val != {W{1'b1}})) begin
            nxt = val + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/match_tally.sv
// Reduces the detector's ans level into event count, run lengths, edge pulse and sticky hit.
module match_tally
    import match_tally_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int RUN_W  = DEF_RUN_W,
    parameter int THRESH = DEF_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ans,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [RUN_W-1:0] run_len,
    output logic [RUN_W-1:0] max_run,
    output logic             edge_o,
    output logic             hit
);

    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

    tally_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [RUN_W-1:0] max_q, max_d;
    logic             edge_q, edge_d;
    logic             hit_q, hit_d;
    logic             rise;

    assign rise = ans && (state_q == T_IDLE);

    sat_inc #(.W(CNT_W)) u_cnt_inc (
        .val (count_q),
        .en  (rise),
        .nxt (count_inc)
    );

    sat_inc #(.W(RUN_W)) u_run_inc (
        .val (run_q),
        .en  (1'b1),
        .nxt (run_inc)
    );

    always_comb begin
        // The FSM keeps tracking ans through clr so a held-high level is not recounted.
        state_d = ans ? T_ACTIVE : T_IDLE;
        count_d = count_inc;
        run_d   = ans ? run_inc : '0;
        max_d   = (run_d > max_q) ? run_d : max_q;
        edge_d  = rise;
        hit_d   = hit_q || (count_inc >= THRESH_V);
        if (clr) begin
            count_d = '0;
            run_d   = '0;
            max_d   = '0;
            edge_d  = 1'b0;
            hit_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T_IDLE;
            count_q <= '0;
            run_q   <= '0;
            max_q   <= '0;
            edge_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            run_q   <= run_d;
            max_q   <= max_d;
            edge_q  <= edge_d;
            hit_q   <= hit_d;
        end
    end

    assign count   = count_q;
    assign run_len = run_q;
    assign max_run = max_q;
    assign edge_o  = edge_q;
    assign hit     = hit_q;

endmodule

// File: tb/tb_match_tally.sv
// Directed bench for match_tally: default widths plus a narrow 3-bit instance for saturation.
module tb_match_tally;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ans0 = 1'b0, clr0 = 1'b0;
    logic       ans1 = 1'b0, clr1 = 1'b0;

    logic [7:0] count0, run0, max0;
    logic       edge0, hit0;
    logic [2:0] count1, run1, max1;
    logic       edge1, hit1;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    match_tally #(.CNT_W(8), .RUN_W(8), .THRESH(4)) u_dut0 (
        .clk(clk), .reset(reset), .ans(ans0), .clr(clr0),
        .count(count0), .run_len(run0), .max_run(max0), .edge_o(edge0), .hit(hit0)
    );

    match_tally #(.CNT_W(3), .RUN_W(3), .THRESH(4)) u_dut1 (
        .clk(clk), .reset(reset), .ans(ans1), .clr(clr1),
        .count(count1), .run_len(run1), .max_run(max1), .edge_o(edge1), .hit(hit1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input int c, input int r, input int m, input int e, input int h);
        chk({tag, ".count0"}, count0, c);
        chk({tag, ".run0"},   run0,   r);
        chk({tag, ".max0"},   max0,   m);
        chk({tag, ".edge0"},  edge0,  e);
        chk({tag, ".hit0"},   hit0,   h);
    endtask

    // Expected per-edge values for the 1,1,1,0,1,0,1,1 pattern
    int pat_a   [8] = '{1, 1, 1, 0, 1, 0, 1, 1};
    int pat_cnt [8] = '{1, 1, 1, 1, 2, 2, 3, 3};
    int pat_edge[8] = '{1, 0, 0, 0, 1, 0, 1, 0};
    int pat_run [8] = '{1, 2, 3, 0, 1, 0, 1, 2};
    int pat_max [8] = '{1, 2, 3, 3, 3, 3, 3, 3};

    initial begin
        // Reset state
        #2;
        chk0("reset", 0, 0, 0, 0, 0);
        chk("reset.count1", count1, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic pattern on the default instance
        for (int i = 0; i < 8; i++) begin
            ans0 = pat_a[i][0];
            tick();
            chk0($sformatf("pat%0d", i), pat_cnt[i], pat_run[i], pat_max[i], pat_edge[i], 0);
        end
        ans0 = 1'b0;
        tick();
        chk0("pat_low", 3, 0, 3, 0, 0);

        // Clear, then threshold with five isolated pulses
        clr0 = 1'b1;
        tick();
        chk0("clr_a", 0, 0, 0, 0, 0);
        clr0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            ans0 = 1'b1;
            tick();
            chk0($sformatf("thr_rise%0d", k), k, 1, 1, 1, (k >= 4) ? 1 : 0);
            ans0 = 1'b0;
            tick();
            chk0($sformatf("thr_low%0d", k), k, 0, 1, 0, (k >= 4) ? 1 : 0);
        end

        // clr coincident with a rise while count=2
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            ans0 = 1'b1;
            tick();
            ans0 = 1'b0;
            tick();
        end
        chk0("pre_clr", 2, 0, 1, 0, 0);
        ans0 = 1'b1;
        clr0 = 1'b1;
        tick();
        chk0("clr_rise", 0, 0, 0, 0, 0);
        clr0 = 1'b0;
        tick();
        chk0("clr_hold1", 0, 1, 1, 0, 0);
        tick();
        chk0("clr_hold2", 0, 2, 2, 0, 0);
        ans0 = 1'b0;
        tick();
        chk0("clr_fall", 0, 0, 2, 0, 0);
        ans0 = 1'b1;
        tick();
        chk0("clr_rerise", 1, 1, 2, 1, 0);
        ans0 = 1'b0;
        tick();

        // Asynchronous reset mid-run
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        ans0 = 1'b1;
        tick();
        tick();
        tick();
        chk0("run3", 1, 3, 3, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk0("async_reset", 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        tick();
        chk0("post_reset", 1, 1, 1, 1, 0);
        ans0 = 1'b0;

        // Count saturation on the 3-bit instance
        for (int k = 1; k <= 9; k++) begin
            ans1 = 1'b1;
            tick();
            chk($sformatf("sat_cnt%0d", k), count1, (k > 7) ? 7 : k);
            chk($sformatf("sat_edge%0d", k), edge1, 1);
            chk($sformatf("sat_hit%0d", k), hit1, (k >= 4) ? 1 : 0);
            ans1 = 1'b0;
            tick();
            chk($sformatf("sat_edgelow%0d", k), edge1, 0);
        end

        // Run-length saturation on the 3-bit instance
        clr1 = 1'b1;
        tick();
        chk("sat_clr.count1", count1, 0);
        chk("sat_clr.hit1", hit1, 0);
        clr1 = 1'b0;
        ans1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("run_len%0d", k), run1, (k > 7) ? 7 : k);
            chk($sformatf("run_max%0d", k), max1, (k > 7) ? 7 : k);
        end
        ans1 = 1'b0;
        tick();
        chk("run_drop.run1", run1, 0);
        chk("run_drop.max1", max1, 7);
        chk("run_drop.count1", count1, 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
